gpr_write_arbiter: RTL and testbench

- Shares the general-purpose register file's single write port between two producers: the in-order writeback stage (port wb) and the multi-cycle execution unit (port mc, mult/div result moves).
- Default fixed priority to wb; a starvation counter forces an mc grant after MAX_WAIT consecutive lost cycles.
- Registered output stage drives the register file's write_enable, write_address and write_data directly.

---
 rtl/gpr_write_arbiter_if.sv | 82 ++++++++
 rtl/gpr_write_arbiter.sv | 157 +++++++++++++++
 tb/tb_gpr_write_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/gpr_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// gpr_write_arbiter_if
//
// Purpose:
//   Groups the signals between the two register-file write producers, the
//   write arbiter and the register file's single write port.
//
// Signals:
//   wb_valid / wb_ready / wb_address / wb_data   writeback-stage request
//   mc_valid / mc_ready / mc_address / mc_data   multi-cycle unit request
//   gpr_write_enable / _address / _data          registered write port
//   mc_forced                                    mc grant forced by starvation
//   (GPR_WRITE_ARBITER_BYPASS_EN only)
//   rd_address_1/2, rf_read_data_1/2             read ports seen by the file
//   bypass_data_1/2                              forwarded read data
//
// Modports:
//   slave  - the arbiter (consumes requests, produces grants/write port)
//   master - the producer/system side (drives requests, observes grants)
//
// Optional feature macro: GPR_WRITE_ARBITER_BYPASS_EN
// ---------------------------------------------------------------------------
interface gpr_write_arbiter_if;

    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_address;
    logic [31:0] wb_data;

    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_address;
    logic [31:0] mc_data;

    logic        gpr_write_enable;
    logic [4:0]  gpr_write_address;
    logic [31:0] gpr_write_data;

    logic        mc_forced;

`ifdef GPR_WRITE_ARBITER_BYPASS_EN
    logic [4:0]  rd_address_1;
    logic [4:0]  rd_address_2;
    logic [31:0] rf_read_data_1;
    logic [31:0] rf_read_data_2;
    logic [31:0] bypass_data_1;
    logic [31:0] bypass_data_2;

    modport slave (
        input  wb_valid, wb_address, wb_data,
        input  mc_valid, mc_address, mc_data,
        output wb_ready, mc_ready, mc_forced,
        output gpr_write_enable, gpr_write_address, gpr_write_data,
        input  rd_address_1, rd_address_2, rf_read_data_1, rf_read_data_2,
        output bypass_data_1, bypass_data_2
    );

    modport master (
        output wb_valid, wb_address, wb_data,
        output mc_valid, mc_address, mc_data,
        input  wb_ready, mc_ready, mc_forced,
        input  gpr_write_enable, gpr_write_address, gpr_write_data,
        output rd_address_1, rd_address_2, rf_read_data_1, rf_read_data_2,
        input  bypass_data_1, bypass_data_2
    );
`else
    modport slave (
        input  wb_valid, wb_address, wb_data,
        input  mc_valid, mc_address, mc_data,
        output wb_ready, mc_ready, mc_forced,
        output gpr_write_enable, gpr_write_address, gpr_write_data
    );

    modport master (
        output wb_valid, wb_address, wb_data,
        output mc_valid, mc_address, mc_data,
        input  wb_ready, mc_ready, mc_forced,
        input  gpr_write_enable, gpr_write_address, gpr_write_data
    );
`endif

endinterface

// File: rtl/gpr_write_arbiter.sv
// ---------------------------------------------------------------------------
// gpr_write_arbiter
//
// Purpose:
//   Shares the general-purpose register file's single write port between the
//   in-order writeback stage (wb) and the multi-cycle execution unit (mc).
//   wb has fixed priority; a saturating starvation counter forces an mc grant
//   once mc has lost MAX_WAIT consecutive cycles while valid. The granted
//   request is registered and drives the register file write port directly.
//
// Parameters:
//   MAX_WAIT   - consecutive denied cycles before a forced mc grant
//                (legal 1 .. 2**WAIT_WIDTH-1)
//   WAIT_WIDTH - width of the starvation counter
//
// Ports:
//   system_clock    rising-edge clock
//   system_reset_n  asynchronous active-low reset
//   bus             gpr_write_arbiter_if.slave (requests, grants, write port,
//                   mc_forced, and bypass read ports when enabled)
//
// Optional feature macro: GPR_WRITE_ARBITER_BYPASS_EN
//   Adds combinational read forwarding from the registered write port so a
//   consumer sees a value in the cycle the file is still committing it.
// ---------------------------------------------------------------------------
module gpr_write_arbiter #(
    parameter int MAX_WAIT   = 4,
    parameter int WAIT_WIDTH = 4
) (
    input  logic                  system_clock,
    input  logic                  system_reset_n,
    gpr_write_arbiter_if.slave    bus
);

    localparam logic [WAIT_WIDTH-1:0] MAX_WAIT_C = WAIT_WIDTH'(MAX_WAIT);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [WAIT_WIDTH-1:0] wait_count_q;
    logic [WAIT_WIDTH-1:0] wait_count_d;

    logic                  gpr_write_enable_q;
    logic                  gpr_write_enable_d;
    logic [4:0]            gpr_write_address_q;
    logic [4:0]            gpr_write_address_d;
    logic [31:0]           gpr_write_data_q;
    logic [31:0]           gpr_write_data_d;

    // -----------------------------------------------------------------------
    // Grant logic
    // -----------------------------------------------------------------------
    logic forced;
    logic mc_grant;
    logic wb_grant;

    // Grants are qualified with the reset input so that nothing is accepted
    // (and no producer believes it transferred) while reset is held.
    always_comb begin
        forced   = system_reset_n && bus.mc_valid && (wait_count_q == MAX_WAIT_C);
        mc_grant = system_reset_n && bus.mc_valid && (!bus.wb_valid || forced);
        wb_grant = system_reset_n && bus.wb_valid && !forced;
    end

    assign bus.wb_ready  = wb_grant;
    assign bus.mc_ready  = mc_grant;
    assign bus.mc_forced = forced;

    // -----------------------------------------------------------------------
    // Starvation counter: counts consecutive cycles mc is valid but denied.
    // It clears whenever mc withdraws or wins, and saturates at MAX_WAIT;
    // reaching MAX_WAIT makes the very next evaluation a forced grant, which
    // then clears it, so the saturation hold only matters defensively.
    // -----------------------------------------------------------------------
    always_comb begin
        wait_count_d = wait_count_q;
        if (!bus.mc_valid || mc_grant) begin
            wait_count_d = '0;
        end else if (wait_count_q != MAX_WAIT_C) begin
            wait_count_d = wait_count_q + WAIT_WIDTH'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Output stage next-state
    // Address/data track the granted port on every transfer, including
    // register 0; only the enable is suppressed for register 0 so x0 stays
    // hard-wired to zero in the file.
    // -----------------------------------------------------------------------
    always_comb begin
        gpr_write_enable_d  = 1'b0;
        gpr_write_address_d = gpr_write_address_q;
        gpr_write_data_d    = gpr_write_data_q;
        if (mc_grant) begin
            gpr_write_address_d = bus.mc_address;
            gpr_write_data_d    = bus.mc_data;
            gpr_write_enable_d  = (bus.mc_address != 5'd0);
        end else if (wb_grant) begin
            gpr_write_address_d = bus.wb_address;
            gpr_write_data_d    = bus.wb_data;
            gpr_write_enable_d  = (bus.wb_address != 5'd0);
        end
    end

    // -----------------------------------------------------------------------
    // Registers. The asynchronous reset drops an in-flight write immediately;
    // producers re-present their requests after reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            wait_count_q        <= '0;
            gpr_write_enable_q  <= 1'b0;
            gpr_write_address_q <= 5'd0;
            gpr_write_data_q    <= 32'd0;
        end else begin
            wait_count_q        <= wait_count_d;
            gpr_write_enable_q  <= gpr_write_enable_d;
            gpr_write_address_q <= gpr_write_address_d;
            gpr_write_data_q    <= gpr_write_data_d;
        end
    end

    assign bus.gpr_write_enable  = gpr_write_enable_q;
    assign bus.gpr_write_address = gpr_write_address_q;
    assign bus.gpr_write_data    = gpr_write_data_q;

`ifdef GPR_WRITE_ARBITER_BYPASS_EN
    // -----------------------------------------------------------------------
    // Read forwarding: during the cycle the registered write is presented the
    // file still returns the old value, so substitute the pending write data.
    // Register 0 is never forwarded (the write to it is never issued anyway).
    // -----------------------------------------------------------------------
    logic [4:0]  rd_address [2];
    logic [31:0] rf_read_data [2];
    logic [31:0] bypass_data [2];

    assign rd_address[0]   = bus.rd_address_1;
    assign rd_address[1]   = bus.rd_address_2;
    assign rf_read_data[0] = bus.rf_read_data_1;
    assign rf_read_data[1] = bus.rf_read_data_2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
        always_comb begin
            bypass_data[gi] = rf_read_data[gi];
            if (gpr_write_enable_q &&
                (gpr_write_address_q == rd_address[gi]) &&
                (rd_address[gi] != 5'd0)) begin
                bypass_data[gi] = gpr_write_data_q;
            end
        end
    end

    assign bus.bypass_data_1 = bypass_data[0];
    assign bus.bypass_data_2 = bypass_data[1];
`endif

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gpr_write_arbiter
//
// Directed, table-driven bench for gpr_write_arbiter (MAX_WAIT=4). A table
// of per-cycle requests and expected grants / registered write port values
// runs back to back from reset, followed by hand-written sequences for reset
// idle, asynchronous reset during a write and (when enabled) read bypass.
// Inputs change on the falling edge; combinational outputs are sampled just
// after that, registered outputs 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_gpr_write_arbiter;

    logic system_clock;
    logic system_reset_n;

    gpr_write_arbiter_if bus ();

    gpr_write_arbiter #(
        .MAX_WAIT   (4),
        .WAIT_WIDTH (4)
    ) dut (
        .system_clock   (system_clock),
        .system_reset_n (system_reset_n),
        .bus            (bus)
    );

    initial system_clock = 1'b0;
    always #5 system_clock = ~system_clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        bus.wb_valid   = wv;
        bus.wb_address = wa;
        bus.wb_data    = wd;
        bus.mc_valid   = mv;
        bus.mc_address = ma;
        bus.mc_data    = md;
    endtask

    typedef struct {
        logic        wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        exp_wb_ready;
        logic        exp_mc_ready;
        logic        exp_forced;
        logic        exp_we;
        logic [4:0]  exp_wa;
        logic [31:0] exp_wd;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    initial begin
        // Inputs                                     | wbr mcr frc | we addr data (after edge)
        vecs[0]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 0, 5'd0,  32'h0};
        vecs[1]  = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        1, 0, 0, 1, 5'd5,  32'hDEADBEEF};
        vecs[2]  = '{0, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        0, 0, 0, 0, 5'd5,  32'hDEADBEEF};
        vecs[3]  = '{1, 5'd0,  32'hFFFFFFFF, 0, 5'd0,  32'h0,        1, 0, 0, 0, 5'd0,  32'hFFFFFFFF};
        vecs[4]  = '{0, 5'd0,  32'h0,        1, 5'd7,  32'hA5A5A5A5, 0, 1, 0, 1, 5'd7,  32'hA5A5A5A5};
        // Contention: wb wins four times, then mc is forced.
        vecs[5]  = '{1, 5'd1,  32'h101,      1, 5'd9,  32'h12345678, 1, 0, 0, 1, 5'd1,  32'h101};
        vecs[6]  = '{1, 5'd2,  32'h102,      1, 5'd9,  32'h12345678, 1, 0, 0, 1, 5'd2,  32'h102};
        vecs[7]  = '{1, 5'd3,  32'h103,      1, 5'd9,  32'h12345678, 1, 0, 0, 1, 5'd3,  32'h103};
        vecs[8]  = '{1, 5'd4,  32'h104,      1, 5'd9,  32'h12345678, 1, 0, 0, 1, 5'd4,  32'h104};
        vecs[9]  = '{1, 5'd5,  32'h105,      1, 5'd9,  32'h12345678, 0, 1, 1, 1, 5'd9,  32'h12345678};
        vecs[10] = '{1, 5'd5,  32'h105,      1, 5'd9,  32'h12345678, 1, 0, 0, 1, 5'd5,  32'h105};
        vecs[11] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 0, 5'd5,  32'h105};
        // Same destination on both ports: wb first, mc afterwards.
        vecs[12] = '{1, 5'd10, 32'hAAAA0000, 1, 5'd10, 32'hBBBB0000, 1, 0, 0, 1, 5'd10, 32'hAAAA0000};
        vecs[13] = '{0, 5'd0,  32'h0,        1, 5'd10, 32'hBBBB0000, 0, 1, 0, 1, 5'd10, 32'hBBBB0000};
        vecs[14] = '{0, 5'd0,  32'h0,        1, 5'd0,  32'h77,       0, 1, 0, 0, 5'd0,  32'h77};
        vecs[15] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 0, 5'd0,  32'h77};
    end

    initial begin
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
`ifdef GPR_WRITE_ARBITER_BYPASS_EN
        bus.rd_address_1   = 5'd0;
        bus.rd_address_2   = 5'd0;
        bus.rf_read_data_1 = 32'h0;
        bus.rf_read_data_2 = 32'h0;
`endif
        system_reset_n = 1'b1;
        #1 system_reset_n = 1'b0;

        // Ready held low while reset is asserted, even with requests present.
        @(negedge system_clock);
        drive(1, 5'd5, 32'h1, 1, 5'd6, 32'h2);
        #1;
        check("reset_wb_ready", 32'(bus.wb_ready), 32'd0);
        check("reset_mc_ready", 32'(bus.mc_ready), 32'd0);
        check("reset_we",       32'(bus.gpr_write_enable), 32'd0);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        @(negedge system_clock);
        system_reset_n = 1'b1;

        // Idle after release: everything stays zero for five cycles.
        for (int c = 0; c < 5; c++) begin
            @(posedge system_clock);
            #1;
            check("idle_we",   32'(bus.gpr_write_enable), 32'd0);
            check("idle_addr", 32'(bus.gpr_write_address), 32'd0);
            check("idle_data", bus.gpr_write_data, 32'd0);
            check("idle_ready", {30'd0, bus.wb_ready, bus.mc_ready}, 32'd0);
            $display("idle cycle %0d checked", c);
        end

        // Table-driven sequence.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge system_clock);
            drive(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].mv, vecs[i].ma, vecs[i].md);
            #1;
            check($sformatf("v%0d_wb_ready", i), 32'(bus.wb_ready),  32'(vecs[i].exp_wb_ready));
            check($sformatf("v%0d_mc_ready", i), 32'(bus.mc_ready),  32'(vecs[i].exp_mc_ready));
            check($sformatf("v%0d_forced", i),   32'(bus.mc_forced), 32'(vecs[i].exp_forced));
            @(posedge system_clock);
            #1;
            check($sformatf("v%0d_we", i),   32'(bus.gpr_write_enable),  32'(vecs[i].exp_we));
            check($sformatf("v%0d_addr", i), 32'(bus.gpr_write_address), 32'(vecs[i].exp_wa));
            check($sformatf("v%0d_data", i), bus.gpr_write_data, vecs[i].exp_wd);
            $display("vec %0d: wb(%0b,%0d,%08h) mc(%0b,%0d,%08h) -> we=%0b addr=%0d data=%08h",
                     i, vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].mv, vecs[i].ma,
                     vecs[i].md, bus.gpr_write_enable, bus.gpr_write_address,
                     bus.gpr_write_data);
        end
        // Counter was cleared by the mc transfer and the idle cycle.
        check("post_table_wait", 32'(dut.wait_count_q), 32'd0);

        // Asynchronous reset during an in-flight write with a non-zero counter.
        for (int c = 0; c < 3; c++) begin
            @(negedge system_clock);
            drive(1, 5'(12 + c), 32'h5555_0000 + 32'(c), 1, 5'd9, 32'h9999);
            @(posedge system_clock);
        end
        #1;
        check("pre_reset_we",   32'(bus.gpr_write_enable), 32'd1);
        check("pre_reset_addr", 32'(bus.gpr_write_address), 32'd14);
        check("pre_reset_wait", 32'(dut.wait_count_q), 32'd3);
        #2 system_reset_n = 1'b0;
        #1;
        check("async_reset_we",     32'(bus.gpr_write_enable), 32'd0);
        check("async_reset_addr",   32'(bus.gpr_write_address), 32'd0);
        check("async_reset_data",   bus.gpr_write_data, 32'd0);
        check("async_reset_wait",   32'(dut.wait_count_q), 32'd0);
        check("async_reset_ready",  {30'd0, bus.wb_ready, bus.mc_ready}, 32'd0);
        check("async_reset_forced", 32'(bus.mc_forced), 32'd0);
        $display("async reset during write checked");
        @(negedge system_clock);
        system_reset_n = 1'b1;
        #1;
        // Requests still presented: wb wins, mc not forced since counter cleared.
        check("post_reset_wb_ready", 32'(bus.wb_ready), 32'd1);
        check("post_reset_forced",   32'(bus.mc_forced), 32'd0);
        @(posedge system_clock);
        #1;
        check("post_reset_we",   32'(bus.gpr_write_enable), 32'd1);
        check("post_reset_addr", 32'(bus.gpr_write_address), 32'd14);
        check("post_reset_wait", 32'(dut.wait_count_q), 32'd1);
        @(negedge system_clock);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

`ifdef GPR_WRITE_ARBITER_BYPASS_EN
        // Write register 3, then read it during the commit cycle.
        @(negedge system_clock);
        drive(1, 5'd3, 32'hCAFEF00D, 0, 5'd0, 32'h0);
        @(posedge system_clock);
        #1;
        bus.rd_address_1   = 5'd3;
        bus.rf_read_data_1 = 32'h1111_1111;
        bus.rd_address_2   = 5'd4;
        bus.rf_read_data_2 = 32'h2222_2222;
        #1;
        check("bypass_hit_1",  bus.bypass_data_1, 32'hCAFEF00D);
        check("bypass_miss_2", bus.bypass_data_2, 32'h2222_2222);
        bus.rd_address_2 = 5'd3;
        #1;
        check("bypass_hit_2",  bus.bypass_data_2, 32'hCAFEF00D);
        bus.rd_address_1 = 5'd0;
        #1;
        check("bypass_r0_1",   bus.bypass_data_1, 32'h1111_1111);
        $display("bypass sequence checked");
        @(negedge system_clock);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        @(posedge system_clock);
        #1;
        check("bypass_after_commit", bus.bypass_data_2, 32'h2222_2222);
`endif

        repeat (2) @(posedge system_clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
